bin_conv_wrapper_mul_arb: RTL and testbench

//  Shares one unsigned A_W x B_W multiplier (the DSP48 multiplier cell, combinational
//   p = a*b) between NUM_REQ requesters in the bin_conv wrapper.

---
 rtl/bin_conv_wrapper_mul_arb.sv | 188 ++++++++++++++++++
 tb/tb_bin_conv_wrapper_mul_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_conv_wrapper_mul_arb.sv
// Round-robin sharing of one external unsigned A_W x B_W multiplier between NUM_REQ requesters.
// Define MUL_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module bin_conv_wrapper_mul_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_W     = 10,
  parameter int unsigned B_W     = 5,
  parameter int unsigned P_W     = 15
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]         mul_a,
  output logic [B_W-1:0]         mul_b,
  input  logic [P_W-1:0]         mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_p
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  stat_gnt,
  output logic [15:0]            stat_stall
`endif
);

  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = 16;

  // Pipeline state
  logic            s1_vld_q,    s1_vld_d;
  logic [ID_W-1:0] s1_id_q,     s1_id_d;
  logic [A_W-1:0]  mul_a_q,     mul_a_d;
  logic [B_W-1:0]  mul_b_q,     mul_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
  logic [P_W-1:0]  rsp_p_q,     rsp_p_d;
  logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Handshake and arbitration terms
  logic               rsp_fire_c;
  logic               s2_load_c;
  logic               s1_load_c;
  logic               any_valid_c;
  logic               accept_c;
  logic [ID_W-1:0]    gnt_c;
  logic               arb_found_c;
  logic [SUM_W-1:0]   arb_sum_c;
  logic [ID_W-1:0]    arb_idx_c;
  logic [A_W-1:0]     sel_a_c;
  logic [B_W-1:0]     sel_b_c;
  logic [NUM_REQ-1:0] req_ready_c;

  assign rsp_fire_c  = rsp_valid_q & rsp_ready;
  assign s2_load_c   = s1_vld_q & (~rsp_valid_q | rsp_fire_c);
  assign s1_load_c   = ~s1_vld_q | s2_load_c;
  assign any_valid_c = |req_valid;
  assign accept_c    = any_valid_c & s1_load_c & ~ap_rst;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    gnt_c       = '0;
    arb_found_c = 1'b0;
    arb_sum_c   = '0;
    arb_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_sum_c = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (arb_sum_c >= SUM_W'(NUM_REQ)) begin
        arb_sum_c = arb_sum_c - SUM_W'(NUM_REQ);
      end
      arb_idx_c = arb_sum_c[ID_W-1:0];
      if (!arb_found_c && req_valid[arb_idx_c]) begin
        arb_found_c = 1'b1;
        gnt_c       = arb_idx_c;
      end
    end
  end

  // Operand mux and ready decode for the granted requester
  always_comb begin
    sel_a_c     = '0;
    sel_b_c     = '0;
    req_ready_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c == ID_W'(i)) begin
        sel_a_c        = req_a[i*A_W +: A_W];
        sel_b_c        = req_b[i*B_W +: B_W];
        req_ready_c[i] = accept_c;
      end
    end
  end

  // Next-state for operand stage, result stage and round-robin pointer
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_id_d     = s1_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    rr_ptr_d    = rr_ptr_q;

    if (s1_load_c) begin
      s1_vld_d = accept_c;
    end
    if (accept_c) begin
      s1_id_d  = gnt_c;
      mul_a_d  = sel_a_c;
      mul_b_d  = sel_b_c;
      rr_ptr_d = (gnt_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_c + ID_W'(1);
    end

    // A draining result is replaced in the same cycle, so no bubble
    if (s2_load_c) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_id_q;
      rsp_p_d     = mul_p;
    end else if (rsp_fire_c) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld_q    <= 1'b0;
      s1_id_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = req_ready_c;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

`ifdef MUL_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] stat_gnt_q,   stat_gnt_d;
  logic [CNT_W-1:0]              stat_stall_q, stat_stall_d;

  // Saturating accept and stall counters
  always_comb begin
    stat_gnt_d   = stat_gnt_q;
    stat_stall_d = stat_stall_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready_c[i] && (stat_gnt_q[i] != {CNT_W{1'b1}})) begin
        stat_gnt_d[i] = stat_gnt_q[i] + CNT_W'(1);
      end
    end
    if (rsp_valid_q && !rsp_ready && (stat_stall_q != {CNT_W{1'b1}})) begin
      stat_stall_d = stat_stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_gnt_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_gnt_q   <= stat_gnt_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_gnt   = stat_gnt_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_bin_conv_wrapper_mul_arb.sv
// Directed bench for bin_conv_wrapper_mul_arb with a scoreboard of expected products.
// Stats checks are included when MUL_ARB_STATS_EN is defined.
module tb_bin_conv_wrapper_mul_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned A_W     = 10;
  localparam int unsigned B_W     = 5;
  localparam int unsigned P_W     = 15;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } exp_t;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [A_W-1:0]         mul_a;
  logic [B_W-1:0]         mul_b;
  logic [P_W-1:0]         mul_p;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [P_W-1:0]         rsp_p;
`ifdef MUL_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]  stat_gnt;
  logic [15:0]            stat_stall;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   gnt_log[$];
  int   rsp_log[$];
  int   t3_gnt[6] = '{0, 1, 2, 3, 0, 1};
  int   t3_p[6]   = '{3, 6, 9, 12, 3, 6};

  always #5 ap_clk = ~ap_clk;

  // External multiplier cell
  assign mul_p = P_W'(mul_a) * P_W'(mul_b);

  bin_conv_wrapper_mul_arb #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
`ifdef MUL_ARB_STATS_EN
    ,
    .stat_gnt  (stat_gnt),
    .stat_stall(stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  // One clock: scoreboard at the falling edge, then return just after the rising edge
  task automatic tick();
    exp_t           e;
    logic [A_W-1:0] av;
    logic [B_W-1:0] bv;
    @(negedge ap_clk);
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (ap_rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          check("ready_without_valid", 32'(req_valid[i]), 32'd1);
          av   = req_a[i*A_W +: A_W];
          bv   = req_b[i*B_W +: B_W];
          e.id = ID_W'(i);
          e.p  = P_W'(av) * P_W'(bv);
          exp_q.push_back(e);
          gnt_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_p", 32'(rsp_p), 32'(e.p));
          rsp_log.push_back(int'(rsp_p));
        end
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, i + 1, 3);

    // T1: reset with every requester valid
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_p", 32'(rsp_p), 32'd0);
    ap_rst = 1'b0;
    #1;
    check("rst_first_gnt", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // T2: single requester, full-scale operands
    gnt_log.delete();
    rsp_log.delete();
    set_ops(2, 1023, 31);
    req_valid = 4'b0100;
    tick();
    check("t2_lat_n1", 32'(rsp_valid), 32'd0);
    tick();
    check("t2_lat_n2", 32'(rsp_valid), 32'd1);
    check("t2_first_p", 32'(rsp_p), 32'd31713);
    check("t2_first_id", 32'(rsp_id), 32'd2);
    tick();
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("t2_accepts", 32'(gnt_log.size()), 32'd4);
    check("t2_rsps", 32'(rsp_log.size()), 32'd4);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    set_ops(2, 3, 3);

    // T3: all requesters valid, round-robin order
    do_reset();
    gnt_log.delete();
    rsp_log.delete();
    req_valid = 4'hF;
    repeat (6) tick();
    req_valid = '0;
    repeat (4) tick();
    check("t3_accepts", 32'(gnt_log.size()), 32'd6);
    check("t3_rsps", 32'(rsp_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gnt_log.size()) check("t3_gnt_order", 32'(gnt_log[k]), 32'(t3_gnt[k]));
      if (k < rsp_log.size()) check("t3_p_seq", 32'(rsp_log[k]), 32'(t3_p[k]));
    end

    // T4: backpressure holds the result and stalls acceptance
    do_reset();
    gnt_log.delete();
    rsp_log.delete();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    tick();
    tick();
    check("t4_accepts_before_stall", 32'(gnt_log.size()), 32'd2);
    for (int k = 0; k < 4; k++) begin
      check("t4_ready_stalled", 32'(req_ready), 32'd0);
      check("t4_rsp_valid_held", 32'(rsp_valid), 32'd1);
      check("t4_rsp_p_held", 32'(rsp_p), 32'd3);
      check("t4_rsp_id_held", 32'(rsp_id), 32'd0);
      tick();
    end
    check("t4_accepts_during_stall", 32'(gnt_log.size()), 32'd2);
    rsp_ready = 1'b1;
    repeat (2) tick();
    req_valid = '0;
    repeat (4) tick();
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_no_loss_dup", 32'(rsp_log.size()), 32'(gnt_log.size()));

    // T5: reset with both stages full
    gnt_log.delete();
    rsp_log.delete();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (3) tick();
    check("t5_s2_full", 32'(rsp_valid), 32'd1);
    ap_rst = 1'b1;
    #1;
    check("t5_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    check("t5_rsp_cleared", 32'(rsp_valid), 32'd0);
    ap_rst = 1'b0;
    #1;
    check("t5_ptr_restart", 32'(req_ready), 32'b0001);
    req_valid = '0;
    rsp_ready = 1'b1;
    rsp_log.delete();
    repeat (4) tick();
    check("t5_no_stale_rsp", 32'(rsp_log.size()), 32'd0);
    check("t5_rsp_idle", 32'(rsp_valid), 32'd0);

`ifdef MUL_ARB_STATS_EN
    // T6: statistics counters
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    repeat (8) tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < NUM_REQ; i++) begin
      check("t6_stat_gnt", 32'(stat_gnt[i*16 +: 16]), 32'd2);
    end
    check("t6_stat_stall", 32'(stat_stall), 32'd4);
    rsp_ready = 1'b1;
    repeat (4) tick();
    check("t6_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
